// File: rtl/clk_div_param.sv
// Parametrised integer clock divider with glitch-free ratio/bypass switching at period boundaries.
// Optional macro CLK_DIV_ODD_DUTY50_EN adds a negedge flop that gives odd ratios a true 50% duty cycle.
module clk_div_param #(
  parameter int RATIO_W   = 8,
  parameter int RST_RATIO = 2
) (
  input  logic               I_ref_clk,
  input  logic               I_rst_n,
  input  logic               I_clk_en,
  input  logic [RATIO_W-1:0] I_div_ratio,
  output logic               O_div_clk,
  output logic               O_div_tick,
  output logic               O_ratio_ack
);

  typedef enum logic {BYPASS = 1'b0, DIVIDE = 1'b1} mode_e;

  localparam logic [RATIO_W-1:0] ONE = {{(RATIO_W-1){1'b0}}, 1'b1};

  mode_e              mode_q;
  logic [RATIO_W-1:0] ratio_q;
  logic [RATIO_W-1:0] cnt_q;
  logic [RATIO_W-1:0] cnt_nxt;
  logic               div_q;
  logic               ack_q;
  logic               div_req;
  logic               wrap;

  // Number of counter states for which div_q is high within one period.
  function automatic logic [RATIO_W-1:0] high_len(input logic [RATIO_W-1:0] r);
`ifdef CLK_DIV_ODD_DUTY50_EN
    return {1'b0, r[RATIO_W-1:1]};
`else
    return {1'b0, r[RATIO_W-1:1]} + {{(RATIO_W-1){1'b0}}, r[0]};
`endif
  endfunction

  // Ratios 0 and 1 have all upper bits clear and therefore request bypass.
  assign div_req = I_clk_en && (I_div_ratio[RATIO_W-1:1] != '0);
  assign wrap    = (cnt_q == ratio_q - ONE);
  assign cnt_nxt = cnt_q + ONE;

  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      mode_q  <= BYPASS;
      ratio_q <= RATIO_W'(RST_RATIO);
      cnt_q   <= '0;
      div_q   <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (mode_q)
        BYPASS: begin
          if (div_req) begin
            mode_q  <= DIVIDE;
            ratio_q <= I_div_ratio;
            cnt_q   <= '0;
            div_q   <= 1'b1;
            ack_q   <= 1'b1;
          end
        end
        DIVIDE: begin
          if (wrap) begin
            cnt_q <= '0;
            div_q <= 1'b1;
            // Bypass request takes priority over a simultaneous ratio change.
            if (!div_req) begin
              mode_q <= BYPASS;
              ack_q  <= 1'b1;
            end else if (I_div_ratio != ratio_q) begin
              ratio_q <= I_div_ratio;
              ack_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_nxt;
            div_q <= (cnt_nxt < high_len(ratio_q));
          end
        end
        default: mode_q <= BYPASS;
      endcase
    end
  end

  assign O_div_tick  = (mode_q == DIVIDE) && (cnt_q == '0);
  assign O_ratio_ack = ack_q;

`ifdef CLK_DIV_ODD_DUTY50_EN
  logic div_n_q;

  // Half-cycle delayed copy stretches the high phase by half a ref period on odd ratios.
  always_ff @(negedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) div_n_q <= 1'b0;
    else          div_n_q <= div_q;
  end

  always_comb begin
    O_div_clk = I_ref_clk;
    if (mode_q == DIVIDE) begin
      if (ratio_q[0]) O_div_clk = div_q | div_n_q;
      else            O_div_clk = div_q;
    end
  end
`else
  assign O_div_clk = (mode_q == DIVIDE) ? div_q : I_ref_clk;
`endif

endmodule

// File: tb/tb_clk_div_param.sv
// Scoreboard bench for clk_div_param: stimulus queues per-cycle expected outputs, a monitor
// samples {clk at high phase, clk at low phase, tick, ack} every ref cycle and compares.
module tb_clk_div_param;

  localparam int RATIO_W = 8;

  logic               ref_clk = 1'b0;
  logic               rst_n;
  logic               clk_en;
  logic [RATIO_W-1:0] div_ratio;
  logic               div_clk;
  logic               div_tick;
  logic               ratio_ack;

  typedef struct {
    int         cyc;
    logic [3:0] e;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  clk_div_param #(.RATIO_W(RATIO_W), .RST_RATIO(2)) dut (
    .I_ref_clk   (ref_clk),
    .I_rst_n     (rst_n),
    .I_clk_en    (clk_en),
    .I_div_ratio (div_ratio),
    .O_div_clk   (div_clk),
    .O_div_tick  (div_tick),
    .O_ratio_ack (ratio_ack)
  );

  always #5 ref_clk = ~ref_clk;

  // Expected {hi, lo, tick, ack} for counter state j of a divided period of ratio n.
  function automatic logic [3:0] pat(input int n, input int j, input bit ack);
    logic hi, lo;
    hi = (j < (n + 1) / 2);
    lo = hi;
`ifdef CLK_DIV_ODD_DUTY50_EN
    if (n % 2 == 1) begin
      hi = (j <= n / 2);
      lo = (j < n / 2);
    end
`endif
    return {hi, lo, (j == 0), (ack && j == 0)};
  endfunction

  // Queue the expectation for the cycle after the next posedge, then wait for that cycle's negedge.
  task automatic nxt(input logic [3:0] e);
    exp_t ent;
    ent.cyc = cyc + 1;
    ent.e   = e;
    sb.push_back(ent);
    @(negedge ref_clk);
  endtask

  task automatic run_period(input int n, input bit ack);
    for (int j = 0; j < n; j++) nxt(pat(n, j, ack));
  endtask

  // Monitor
  initial begin
    logic       hi_s, tick_s, ack_s, lo_s;
    logic [3:0] got;
    exp_t       ent;
    forever begin
      @(posedge ref_clk);
      #1;
      cyc++;
      hi_s   = div_clk;
      tick_s = div_tick;
      ack_s  = ratio_ack;
      @(negedge ref_clk);
      #1;
      lo_s = div_clk;
      got  = {hi_s, lo_s, tick_s, ack_s};
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        ent = sb.pop_front();
        chk_cnt++;
        if (ent.cyc == cyc && got === ent.e) pass_cnt++;
        else $display("FAIL cycle %0d {clk_hi,clk_lo,tick,ack} got %b expected %b (entry cycle %0d)",
                      cyc, got, ent.e, ent.cyc);
      end
    end
  end

  // Stimulus
  initial begin
    rst_n     = 1'b0;
    clk_en    = 1'b0;
    div_ratio = 8'd5;
    @(negedge ref_clk);
    nxt(4'b1000);
    nxt(4'b1000);
    rst_n = 1'b1;
    // Bypass with enable low: output follows ref clock.
    nxt(4'b1000);
    nxt(4'b1000);
    nxt(4'b1000);

    // Enable at ratio 4: ack with first tick, 1,1,0,0 pattern.
    clk_en    = 1'b1;
    div_ratio = 8'd4;
    run_period(4, 1'b1);
    run_period(4, 1'b0);
    nxt(pat(4, 0, 1'b0));
    nxt(pat(4, 1, 1'b0));
    // Ratio write at cnt 1 is deferred to the wrap.
    div_ratio = 8'd6;
    nxt(pat(4, 2, 1'b0));
    nxt(pat(4, 3, 1'b0));

    nxt(pat(6, 0, 1'b1));
    nxt(pat(6, 1, 1'b1));
    nxt(pat(6, 2, 1'b1));
    div_ratio = 8'd5;
    nxt(pat(6, 3, 1'b0));
    nxt(pat(6, 4, 1'b0));
    nxt(pat(6, 5, 1'b0));

    run_period(5, 1'b1);
    nxt(pat(5, 0, 1'b0));
    nxt(pat(5, 1, 1'b0));
    nxt(pat(5, 2, 1'b0));
    // Ratio 1 with enable high forces bypass, but only at the wrap.
    div_ratio = 8'd1;
    nxt(pat(5, 3, 1'b0));
    nxt(pat(5, 4, 1'b0));
    nxt(4'b1001);
    nxt(4'b1000);
    nxt(4'b1000);

    // Enable drop together with a ratio change mid-period: bypass wins at the wrap.
    div_ratio = 8'd4;
    nxt(pat(4, 0, 1'b1));
    nxt(pat(4, 1, 1'b1));
    clk_en    = 1'b0;
    div_ratio = 8'd7;
    nxt(pat(4, 2, 1'b0));
    nxt(pat(4, 3, 1'b0));
    nxt(4'b1001);
    nxt(4'b1000);

    // Largest ratio, then async reset at cnt 100.
    clk_en    = 1'b1;
    div_ratio = 8'd255;
    run_period(255, 1'b1);
    for (int j = 0; j < 100; j++) nxt(pat(255, j, 1'b0));
    nxt(4'b1000);
    rst_n = 1'b0;
    nxt(4'b1000);
    nxt(4'b1000);
    clk_en = 1'b0;
    rst_n  = 1'b1;
    nxt(4'b1000);

    @(negedge ref_clk);
    @(negedge ref_clk);
    chk_cnt++;
    if (sb.size() == 0) pass_cnt++;
    else $display("FAIL scoreboard_drain pending %0d expected 0", sb.size());
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
